vending_ctrl: RTL and testbench

//  Main sequencer for the two-product vending machine (coffee, tea): accumulates coin

---
 rtl/vending_ctrl_pkg.sv | 15 +
 rtl/vending_ctrl_idle_timer.sv | 45 ++++
 rtl/vending_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_vending_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vending_ctrl_pkg.sv
// Shared definitions for the two-product vending sequencer: state
// encodings and coin face values.
package vending_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam int unsigned COIN1 = 32'd1;
    localparam int unsigned COIN5 = 32'd5;

endpackage

// File: rtl/vending_ctrl_idle_timer.sv
// Idle timer for the CREDIT state: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT-th idle cycle occurs.
module vending_ctrl_idle_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 32'd1);
    localparam logic [TW-1:0] ONE  = TW'(32'd1);

    logic [TW-1:0] count_r;
    logic [TW-1:0] count_s;

    // The current count is the number of idle cycles already seen, so the
    // TIMEOUT-th idle cycle is the one where the count equals TIMEOUT-1.
    assign expired = (count_r == LAST);

    // Next count: clear wins, otherwise advance while enabled and not yet expired.
    always_comb begin
        count_s = count_r;
        if (clear) begin
            count_s = {TW{1'b0}};
        end else if (enable && !expired) begin
            count_s = count_r + ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {TW{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

endmodule

// File: rtl/vending_ctrl.sv
// Main sequencer of the coffee/tea vending machine: accumulates coin
// credit, checks a selection against its price, drives the dispenser with
// a req/ack handshake and pays change back one leu at a time.
module vending_ctrl
    import vending_ctrl_pkg::*;
#(
    parameter int unsigned PRICE_CAFEA = 2,
    parameter int unsigned PRICE_CEAI  = 1,
    parameter int unsigned CREDIT_W    = 4,
    parameter int unsigned MAX_CREDIT  = 9,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_1,
    input  logic                coin_5,
    input  logic                sel_cafea,
    input  logic                sel_ceai,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                rest_ack,
    output logic                disp_cafea,
    output logic                disp_ceai,
    output logic                rest_req,
    output logic                coin_reject,
    output logic                low_credit,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] P_CAFEA  = CREDIT_W'(PRICE_CAFEA);
    localparam logic [CREDIT_W-1:0] P_CEAI   = CREDIT_W'(PRICE_CEAI);
    localparam logic [CREDIT_W-1:0] V_COIN1  = CREDIT_W'(COIN1);
    localparam logic [CREDIT_W-1:0] V_COIN5  = CREDIT_W'(COIN5);
    localparam logic [CREDIT_W-1:0] ONE_LEU  = CREDIT_W'(32'd1);
    localparam logic [CREDIT_W-1:0] ZERO_LEU = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W:0]   MAX_EXT  = (CREDIT_W + 32'd1)'(MAX_CREDIT);

    state_t              state_r;
    state_t              state_s;
    logic [CREDIT_W-1:0] credit_r;
    logic [CREDIT_W-1:0] credit_s;
    logic                disp_cafea_r;
    logic                disp_cafea_s;
    logic                disp_ceai_r;
    logic                disp_ceai_s;
    logic                rest_req_r;
    logic                rest_req_s;
    logic                coin_reject_r;
    logic                coin_reject_s;
    logic                low_credit_r;
    logic                low_credit_s;

    logic                coin_any_s;
    logic [CREDIT_W-1:0] coin_val_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_fits_s;
    logic                timer_clear_s;
    logic                timer_en_s;
    logic                timer_expired_s;

    // A simultaneous coin_5 takes precedence over coin_1; the sum is one
    // bit wider so the MAX_CREDIT test cannot wrap.
    assign coin_any_s  = coin_1 | coin_5;
    assign coin_val_s  = coin_5 ? V_COIN5 : V_COIN1;
    assign coin_sum_s  = {1'b0, credit_r} + {1'b0, coin_val_s};
    assign coin_fits_s = (coin_sum_s <= MAX_EXT);

    vending_ctrl_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (timer_expired_s)
    );

    // Next-state, credit and output-register logic for the sequencer.
    always_comb begin
        state_s       = state_r;
        credit_s      = credit_r;
        disp_cafea_s  = disp_cafea_r;
        disp_ceai_s   = disp_ceai_r;
        rest_req_s    = rest_req_r;
        coin_reject_s = 1'b0;
        low_credit_s  = 1'b0;
        timer_clear_s = 1'b1;
        timer_en_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Selections and cancel have nothing to act on with zero credit.
                if (coin_any_s && coin_fits_s) begin
                    credit_s      = coin_sum_s[CREDIT_W-1:0];
                    state_s       = ST_CREDIT;
                    coin_reject_s = coin_1 & coin_5;
                end else begin
                    coin_reject_s = coin_any_s;
                end
            end

            ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_s = coin_any_s;
                    rest_req_s    = 1'b1;
                    state_s       = ST_CHANGE;
                end else if (sel_cafea) begin
                    coin_reject_s = coin_any_s;
                    if (credit_r >= P_CAFEA) begin
                        credit_s     = credit_r - P_CAFEA;
                        disp_cafea_s = 1'b1;
                        state_s      = ST_DISPENSE;
                    end else begin
                        low_credit_s = 1'b1;
                    end
                end else if (sel_ceai) begin
                    coin_reject_s = coin_any_s;
                    if (credit_r >= P_CEAI) begin
                        credit_s    = credit_r - P_CEAI;
                        disp_ceai_s = 1'b1;
                        state_s     = ST_DISPENSE;
                    end else begin
                        low_credit_s = 1'b1;
                    end
                end else if (coin_any_s && coin_fits_s) begin
                    credit_s      = coin_sum_s[CREDIT_W-1:0];
                    coin_reject_s = coin_1 & coin_5;
                end else begin
                    // Nothing counted this cycle: it is an idle cycle.
                    coin_reject_s = coin_any_s;
                    timer_clear_s = 1'b0;
                    timer_en_s    = 1'b1;
                    if (timer_expired_s) begin
                        rest_req_s = 1'b1;
                        state_s    = ST_CHANGE;
                    end else begin
                        state_s = ST_CREDIT;
                    end
                end
            end

            ST_DISPENSE: begin
                coin_reject_s = coin_any_s;
                if (disp_ack) begin
                    disp_cafea_s = 1'b0;
                    disp_ceai_s  = 1'b0;
                    if (credit_r != ZERO_LEU) begin
                        rest_req_s = 1'b1;
                        state_s    = ST_CHANGE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DISPENSE;
                end
            end

            ST_CHANGE: begin
                coin_reject_s = coin_any_s;
                if (rest_ack) begin
                    // The last leu drops rest_req on the same edge; never go below zero.
                    if (credit_r <= ONE_LEU) begin
                        credit_s   = ZERO_LEU;
                        rest_req_s = 1'b0;
                        state_s    = ST_IDLE;
                    end else begin
                        credit_s   = credit_r - ONE_LEU;
                        rest_req_s = 1'b1;
                    end
                end else begin
                    rest_req_s = 1'b1;
                end
            end

            default: begin
                state_s      = ST_IDLE;
                credit_s     = ZERO_LEU;
                disp_cafea_s = 1'b0;
                disp_ceai_s  = 1'b0;
                rest_req_s   = 1'b0;
            end
        endcase
    end

    // State, credit and output registers; reset discards any credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            credit_r      <= ZERO_LEU;
            disp_cafea_r  <= 1'b0;
            disp_ceai_r   <= 1'b0;
            rest_req_r    <= 1'b0;
            coin_reject_r <= 1'b0;
            low_credit_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            credit_r      <= credit_s;
            disp_cafea_r  <= disp_cafea_s;
            disp_ceai_r   <= disp_ceai_s;
            rest_req_r    <= rest_req_s;
            coin_reject_r <= coin_reject_s;
            low_credit_r  <= low_credit_s;
        end
    end

    assign disp_cafea  = disp_cafea_r;
    assign disp_ceai   = disp_ceai_r;
    assign rest_req    = rest_req_r;
    assign coin_reject = coin_reject_r;
    assign low_credit  = low_credit_r;
    assign credit      = credit_r;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: each driven cycle runs a behavioural model that
// pushes the expected output snapshot into a queue; a monitor pops and
// compares after every active edge.
module tb_vending_ctrl;

    localparam int TIMEOUT     = 255;
    localparam int MAX_CREDIT  = 9;
    localparam int PRICE_CAFEA = 2;
    localparam int PRICE_CEAI  = 1;

    // Stimulus bit masks: {reset, coin_1, coin_5, sel_cafea, sel_ceai, cancel, disp_ack, rest_ack}
    localparam logic [7:0] I_NONE = 8'h00;
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_C1   = 8'h40;
    localparam logic [7:0] I_C5   = 8'h20;
    localparam logic [7:0] I_SC   = 8'h10;
    localparam logic [7:0] I_ST   = 8'h08;
    localparam logic [7:0] I_CN   = 8'h04;
    localparam logic [7:0] I_DA   = 8'h02;
    localparam logic [7:0] I_RA   = 8'h01;

    logic       clk = 1'b0;
    logic       reset, coin_1, coin_5, sel_cafea, sel_ceai, cancel, disp_ack, rest_ack;
    logic       disp_cafea, disp_ceai, rest_req, coin_reject, low_credit;
    logic [3:0] credit;

    always #5 clk = ~clk;

    vending_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .coin_1      (coin_1),
        .coin_5      (coin_5),
        .sel_cafea   (sel_cafea),
        .sel_ceai    (sel_ceai),
        .cancel      (cancel),
        .disp_ack    (disp_ack),
        .rest_ack    (rest_ack),
        .disp_cafea  (disp_cafea),
        .disp_ceai   (disp_ceai),
        .rest_req    (rest_req),
        .coin_reject (coin_reject),
        .low_credit  (low_credit),
        .credit      (credit)
    );

    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    string      phase    = "reset";

    // Reference model: money held, which product (if any) is being
    // dispensed, whether change is being paid, and idle cycles with credit.
    int m_credit  = 0;
    int m_product = 0;   // 0 none, 1 coffee, 2 tea
    bit m_refund  = 1'b0;
    int m_idle    = 0;

    task automatic model(input logic [7:0] v, output logic [8:0] e);
        bit r, c1, c5, sc, st, cn, da, ra, rej, low, counted;
        int price, val;
        {r, c1, c5, sc, st, cn, da, ra} = v;
        rej = 1'b0;
        low = 1'b0;
        counted = 1'b0;
        if (r) begin
            m_credit = 0; m_product = 0; m_refund = 1'b0; m_idle = 0;
        end else if (m_product != 0) begin
            rej = c1 | c5;
            if (da) begin
                m_product = 0;
                m_refund  = (m_credit > 0);
            end
        end else if (m_refund) begin
            rej = c1 | c5;
            if (ra && m_credit > 0) begin
                m_credit = m_credit - 1;
                if (m_credit == 0) m_refund = 1'b0;
            end
        end else if (m_credit > 0 && (cn || sc || st)) begin
            rej = c1 | c5;
            m_idle = 0;
            if (cn) begin
                m_refund = 1'b1;
            end else begin
                price = sc ? PRICE_CAFEA : PRICE_CEAI;
                if (m_credit >= price) begin
                    m_credit  = m_credit - price;
                    m_product = sc ? 1 : 2;
                end else begin
                    low = 1'b1;
                end
            end
        end else begin
            if (c1 || c5) begin
                val = c5 ? 5 : 1;
                rej = c1 && c5;
                if (m_credit + val <= MAX_CREDIT) begin
                    m_credit = m_credit + val;
                    counted  = 1'b1;
                end else begin
                    rej = 1'b1;
                end
            end
            if (counted) begin
                m_idle = 0;
            end else if (m_credit > 0) begin
                m_idle = m_idle + 1;
                if (m_idle >= TIMEOUT) begin
                    m_refund = 1'b1;
                    m_idle   = 0;
                end
            end else begin
                m_idle = 0;
            end
        end
        e = {m_product == 1, m_product == 2, m_refund, rej, low, 4'(m_credit)};
    endtask

    task automatic step(input logic [7:0] v);
        logic [8:0] e;
        @(negedge clk);
        {reset, coin_1, coin_5, sel_cafea, sel_ceai, cancel, disp_ack, rest_ack} = v;
        model(v, e);
        exp_q.push_back(e);
        tag_q.push_back(phase);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(I_NONE);
    endtask

    // Monitor: compare the DUT outputs after every edge that has an expectation queued.
    initial begin : monitor
        logic [8:0] e;
        logic [8:0] got;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = {disp_cafea, disp_ceai, rest_req, coin_reject, low_credit, credit};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL %s: {disp_cafea,disp_ceai,rest_req,coin_reject,low_credit,credit} got %b_%b_%b_%b_%b_%0d required %b_%b_%b_%b_%b_%0d",
                              t, got[8], got[7], got[6], got[5], got[4], got[3:0],
                              e[8], e[7], e[6], e[5], e[4], e[3:0]);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] v;
        {reset, coin_1, coin_5, sel_cafea, sel_ceai, cancel, disp_ack, rest_ack} = 8'h00;

        phase = "reset";
        step(I_RST); step(I_RST);

        phase = "coffee_exact";
        step(I_C1); step(I_C1); step(I_SC); idle(2); step(I_DA); idle(2);

        phase = "coffee_change";
        step(I_C5); step(I_SC); idle(1); step(I_RA); step(I_DA);
        idle(1); step(I_RA); step(I_DA | I_RA); idle(1); step(I_RA); idle(2);

        phase = "low_credit";
        step(I_C1); step(I_SC); idle(1); step(I_CN | I_C1); idle(1); step(I_RA); idle(1);
        step(I_CN); idle(1);

        phase = "tea";
        step(I_C1); step(I_ST | I_C5); step(I_C1); step(I_DA); idle(1);

        phase = "max_credit";
        step(I_C5); step(I_C1); step(I_C1); step(I_C1); step(I_C1); step(I_C1); step(I_C5); idle(1);
        step(I_CN); for (int i = 0; i < 9; i++) step(I_RA); idle(1);
        step(I_C1 | I_C5); idle(1); step(I_C1 | I_C5);
        step(I_CN); for (int i = 0; i < 9; i++) step(I_RA); idle(1);

        phase = "timeout";
        step(I_C1); idle(TIMEOUT); step(I_C1); step(I_RA); idle(2);

        phase = "reset_mid";
        step(I_C1); step(I_C1); step(I_SC); step(I_RST); idle(1); step(I_DA); idle(1);

        phase = "random";
        for (int k = 0; k < 3000; k++) begin
            v = I_NONE;
            if ($urandom_range(0, 199) == 0)  v = v | I_RST;
            if ($urandom_range(0, 99) < 15)   v = v | I_C1;
            if ($urandom_range(0, 99) < 12)   v = v | I_C5;
            if ($urandom_range(0, 99) < 8)    v = v | I_SC;
            if ($urandom_range(0, 99) < 8)    v = v | I_ST;
            if ($urandom_range(0, 99) < 4)    v = v | I_CN;
            if ($urandom_range(0, 99) < 30)   v = v | I_DA;
            if ($urandom_range(0, 99) < 30)   v = v | I_RA;
            step(v);
        end

        phase = "random_timeout";
        step(I_RST); step(I_C5); idle(TIMEOUT - 1); step(I_C1 | I_C5);
        for (int i = 0; i < 6; i++) step(I_RA);
        idle(2);

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: pending expectations %0d required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
